// File: rtl/seq_mul_div_if.sv
// seq_mul_div_if -- request/result bundle for the sequential multiplier/divider.
//   master: drives start, mode, op_a, op_b, abort; observes busy, done, hi, lo, div_by_zero
//   slave : the arithmetic unit (seq_mul_div)
//   start       request, sampled on a rising clock edge while busy=0
//   mode        00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div
//   op_a/op_b   multiplicand/dividend and multiplier/divisor
//   abort       synchronous cancel of a running operation
//   busy        high while an accepted operation is in progress
//   done        one-cycle pulse marking hi/lo valid
//   hi/lo       mul: upper/lower product half; div: remainder/quotient
//   div_by_zero set with done when a division had op_b=0
interface seq_mul_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, mode, op_a, op_b, abort,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, mode, op_a, op_b, abort,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/seq_mul_div.sv
// seq_mul_div -- sequential WIDTH x WIDTH multiplier / divider, one bit per cycle.
//   clk  single clock, rising edge
//   clr  asynchronous active-low reset
//   bus  seq_mul_div_if.slave: start/mode/op_a/op_b/abort in,
//        busy/done/hi/lo/div_by_zero out
// Operation: IDLE -> PREP (magnitudes, signs, zero-divisor check) ->
// CALC (WIDTH iterations) -> FIX (sign correction, result load, done).
// Result valid with done at E0+WIDTH+2 (E0+2 for divide by zero).
module seq_mul_div #(
    parameter int WIDTH     = 32,
    parameter int SIGNED_EN = 1
) (
    input logic          clk,
    input logic          clr,
    seq_mul_div_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PREP = 2'd1;
    localparam logic [1:0] CALC = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       mode_r;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] m_reg;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc;      // product upper half or partial remainder
    logic [WIDTH-1:0] q;        // multiplier (shifted out) or quotient (shifted in)
    logic [CNT_W-1:0] cnt;
    logic             neg_lo;   // negate product / quotient in FIX
    logic             neg_hi;   // negate remainder in FIX
    logic             dbz_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             dbz_out;

    logic               is_div;
    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ok;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        is_div    = mode_r[1];
        is_signed = mode_r[0] && (SIGNED_EN != 0);
        a_neg     = is_signed && a_in[WIDTH-1];
        b_neg     = is_signed && b_in[WIDTH-1];
        a_mag     = a_neg ? -a_in : a_in;
        b_mag     = b_neg ? -b_in : b_in;

        // Shift-add: add multiplicand when the current multiplier bit is set.
        mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, m_reg} : '0);

        // Restoring step: remainder always stays below the divisor, so the
        // low WIDTH bits of the difference are exact whenever it is kept.
        div_shift = {acc, q[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, m_reg});
        div_sub   = div_shift[WIDTH-1:0] - m_reg;

        prod_fix  = neg_lo ? -{acc, q} : {acc, q};
        quot_fix  = neg_lo ? -q : q;
        rem_fix   = neg_hi ? -acc : acc;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            mode_r  <= '0;
            a_in    <= '0;
            b_in    <= '0;
            m_reg   <= '0;
            acc     <= '0;
            q       <= '0;
            cnt     <= '0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            dbz_r   <= 1'b0;
            done_r  <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            dbz_out <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state != IDLE && bus.abort) begin
                // Cancel wins over any pending completion; outputs untouched.
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            mode_r <= bus.mode;
                            a_in   <= bus.op_a;
                            b_in   <= bus.op_b;
                            state  <= PREP;
                        end
                    end
                    PREP: begin
                        acc    <= '0;
                        cnt    <= '0;
                        neg_lo <= a_neg ^ b_neg;
                        neg_hi <= is_div && a_neg;
                        dbz_r  <= is_div && (b_in == '0);
                        if (is_div) begin
                            m_reg <= b_mag;
                            q     <= a_mag;
                        end else begin
                            m_reg <= a_mag;
                            q     <= b_mag;
                        end
                        state <= (is_div && (b_in == '0)) ? FIX : CALC;
                    end
                    CALC: begin
                        if (is_div) begin
                            acc <= div_ok ? div_sub : div_shift[WIDTH-1:0];
                            q   <= {q[WIDTH-2:0], div_ok};
                        end else begin
                            acc <= mul_sum[WIDTH:1];
                            q   <= {mul_sum[0], q[WIDTH-1:1]};
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        if (dbz_r) begin
                            lo_r <= '1;
                            hi_r <= a_in;
                        end else if (is_div) begin
                            lo_r <= quot_fix;
                            hi_r <= rem_fix;
                        end else begin
                            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_r <= prod_fix[WIDTH-1:0];
                        end
                        dbz_out <= dbz_r;
                        done_r  <= 1'b1;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.div_by_zero = dbz_out;

endmodule
